mr_addr_sequencer: RTL

//  Parametrised address-path sequencer for the Maquina Rudimentaria CPU.

---
 rtl/mr_addr_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mr_addr_sequencer.sv
// Address-path sequencer for the Maquina Rudimentaria: IR/PC/RDIR, fetch/address/access/branch FSM.
// Optional MR_ADDR_OVF_EN adds addr_ovf, the carry-out of the RDIR adder captured in ADDR.
module mr_addr_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [ADDR_W-1:0]  regb,
  input  logic               br_taken,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  rdir,
  output logic               busy,
  output logic               done
`ifdef MR_ADDR_OVF_EN
  ,output logic              addr_ovf
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ADDR, S_ACCESS, S_BRJMP, S_DONE
  } state_e;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_ALU    = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rdir_q, rdir_d;
  logic [1:0]         opcode;
  logic [ADDR_W-1:0]  offset;
  logic [ADDR_W-1:0]  ea_sum;

  assign opcode = ir_q[INSTR_W-1 -: 2];
  assign offset = ir_q[ADDR_W-1:0];

`ifdef MR_ADDR_OVF_EN
  logic [ADDR_W:0] ea_wide;
  logic            addr_ovf_q, addr_ovf_d;

  assign ea_wide  = {1'b0, regb} + {1'b0, offset};
  assign ea_sum   = ea_wide[ADDR_W-1:0];
  assign addr_ovf = addr_ovf_q;
`else
  assign ea_sum = regb + offset;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
      rdir_q  <= '0;
`ifdef MR_ADDR_OVF_EN
      addr_ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      rdir_q  <= rdir_d;
`ifdef MR_ADDR_OVF_EN
      addr_ovf_q <= addr_ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    rdir_d  = rdir_q;
`ifdef MR_ADDR_OVF_EN
    addr_ovf_d = addr_ovf_q;
`endif
    unique case (state_q)
      S_IDLE: if (go) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        rdir_d = ea_sum;
`ifdef MR_ADDR_OVF_EN
        addr_ovf_d = ea_wide[ADDR_W];
`endif
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = S_ACCESS;
          OP_ALU:            state_d = S_DONE;
          OP_BRANCH:         state_d = br_taken ? S_BRJMP : S_DONE;
          default:           state_d = S_DONE;
        endcase
      end
      S_ACCESS: if (mem_ack) state_d = S_DONE;
      S_BRJMP: begin
        pc_d    = rdir_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so nothing flows combinationally from inputs.
  assign mem_req  = (state_q == S_FETCH) || (state_q == S_ACCESS);
  assign mem_we   = (state_q == S_ACCESS) && (opcode == OP_STORE);
  assign mem_addr = (state_q == S_ACCESS) ? rdir_q : pc_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign ir       = ir_q;
  assign pc       = pc_q;
  assign rdir     = rdir_q;

endmodule
